// File: rtl/fnd_set_ctrl.sv
// Time-set controller: mode FSM, increment pulses, field blink enables and
// the decoder refresh clock for the six-digit FND display.
module fnd_set_ctrl #(
    parameter int unsigned BLINK_HALF     = 25_000_000,
    parameter int unsigned REFRESH_HALF   = 25_000,
    parameter int unsigned TIMEOUT_HALVES = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_mode_pulse,
    input  logic       i_pos_pulse,
    input  logic       i_inc_pulse,
    output logic [1:0] o_mode,
    output logic       o_dis_hour,
    output logic       o_dis_min,
    output logic       o_dis_sec,
    output logic       o_blink_clk,
    output logic       o_inc_sec,
    output logic       o_inc_min,
    output logic       o_inc_hour
);

    localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned RW = (REFRESH_HALF > 1) ? $clog2(REFRESH_HALF) : 1;
    localparam int unsigned IW = ($clog2(TIMEOUT_HALVES + 1) > 1) ? $clog2(TIMEOUT_HALVES + 1) : 1;

    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_HALF - 1);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_HALF - 1);
    localparam logic [IW-1:0] IDLE_MAX     = IW'(TIMEOUT_HALVES);

    typedef enum logic [1:0] {
        CLOCK    = 2'd0,
        SET_SEC  = 2'd1,
        SET_MIN  = 2'd2,
        SET_HOUR = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] blink_cnt, blink_cnt_nxt;
    logic          phase, phase_nxt;
    logic [IW-1:0] idle, idle_nxt, idle_inc;
    logic [RW-1:0] refresh_cnt;
    logic [2:0]    inc_q, inc_nxt;      // {hour, min, sec}
    logic [2:0]    dis_q, dis_nxt;      // {hour, min, sec}
    logic          blink_wrap, clear, timeout;

    always_comb begin
        state_nxt = state;
        inc_nxt   = '0;
        clear     = 1'b0;

        blink_wrap = (blink_cnt == BLINK_LAST);
        idle_inc   = (idle < IDLE_MAX) ? idle + 1'b1 : idle;
        // Leave on the wrap that brings the idle count to its limit, not one cycle later.
        timeout    = blink_wrap && (idle_inc == IDLE_MAX);

        if (state == CLOCK) begin
            if (i_mode_pulse) begin
                state_nxt = SET_SEC;
                clear     = 1'b1;
            end
        end else begin
            if (i_mode_pulse) begin
                state_nxt = CLOCK;
                clear     = 1'b1;
            end else if (i_pos_pulse) begin
                clear = 1'b1;
                case (state)
                    SET_SEC: state_nxt = SET_MIN;
                    SET_MIN: state_nxt = SET_HOUR;
                    default: state_nxt = SET_SEC;
                endcase
            end else if (i_inc_pulse) begin
                clear = 1'b1;
                case (state)
                    SET_SEC: inc_nxt = 3'b001;
                    SET_MIN: inc_nxt = 3'b010;
                    default: inc_nxt = 3'b100;
                endcase
            end else if (timeout) begin
                state_nxt = CLOCK;
            end
        end

        if (clear || blink_wrap) begin
            blink_cnt_nxt = '0;
        end else begin
            blink_cnt_nxt = blink_cnt + 1'b1;
        end

        if (clear) begin
            phase_nxt = 1'b1;
        end else if (blink_wrap) begin
            phase_nxt = ~phase;
        end else begin
            phase_nxt = phase;
        end

        if (state_nxt == CLOCK || clear) begin
            idle_nxt = '0;
        end else if (blink_wrap) begin
            idle_nxt = idle_inc;
        end else begin
            idle_nxt = idle;
        end

        dis_nxt = '1;
        case (state_nxt)
            SET_SEC:  dis_nxt[0] = phase_nxt;
            SET_MIN:  dis_nxt[1] = phase_nxt;
            SET_HOUR: dis_nxt[2] = phase_nxt;
            default:  dis_nxt    = '1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= CLOCK;
            blink_cnt <= '0;
            phase     <= 1'b1;
            idle      <= '0;
            inc_q     <= '0;
            dis_q     <= '1;
        end else begin
            state     <= state_nxt;
            blink_cnt <= blink_cnt_nxt;
            phase     <= phase_nxt;
            idle      <= idle_nxt;
            inc_q     <= inc_nxt;
            dis_q     <= dis_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            o_blink_clk <= 1'b0;
        end else if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt <= '0;
            o_blink_clk <= ~o_blink_clk;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    assign o_mode     = state;
    assign o_inc_sec  = inc_q[0];
    assign o_inc_min  = inc_q[1];
    assign o_inc_hour = inc_q[2];
    assign o_dis_sec  = dis_q[0];
    assign o_dis_min  = dis_q[1];
    assign o_dis_hour = dis_q[2];

endmodule

// File: tb/tb_fnd_set_ctrl.sv
// Directed bench for fnd_set_ctrl with short blink/refresh/timeout periods.
module tb_fnd_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_mode_pulse, i_pos_pulse, i_inc_pulse;
    logic [1:0] o_mode;
    logic       o_dis_hour, o_dis_min, o_dis_sec;
    logic       o_blink_clk;
    logic       o_inc_sec, o_inc_min, o_inc_hour;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    fnd_set_ctrl #(
        .BLINK_HALF    (4),
        .REFRESH_HALF  (2),
        .TIMEOUT_HALVES(3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mode_pulse(i_mode_pulse),
        .i_pos_pulse (i_pos_pulse),
        .i_inc_pulse (i_inc_pulse),
        .o_mode      (o_mode),
        .o_dis_hour  (o_dis_hour),
        .o_dis_min   (o_dis_min),
        .o_dis_sec   (o_dis_sec),
        .o_blink_clk (o_blink_clk),
        .o_inc_sec   (o_inc_sec),
        .o_inc_min   (o_inc_min),
        .o_inc_hour  (o_inc_hour)
    );

    always #5 clk = ~clk;

    wire [2:0] dis = {o_dis_hour, o_dis_min, o_dis_sec};
    wire [2:0] inc = {o_inc_hour, o_inc_min, o_inc_sec};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive pulses for one cycle; outputs are sampled 1 time unit after the edge.
    task automatic tick(input logic m, input logic p, input logic i);
        i_mode_pulse = m;
        i_pos_pulse  = p;
        i_inc_pulse  = i;
        @(posedge clk);
        #1;
        i_mode_pulse = 1'b0;
        i_pos_pulse  = 1'b0;
        i_inc_pulse  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        i_mode_pulse = 1'b0;
        i_pos_pulse  = 1'b0;
        i_inc_pulse  = 1'b0;
        tick(0, 0, 0);
        tick(0, 0, 0);
        check("rst_mode", 32'(o_mode), 0);
        check("rst_dis", 32'(dis), 3'b111);
        check("rst_bclk", 32'(o_blink_clk), 0);
        check("rst_inc", 32'(inc), 0);

        // Refresh clock toggles every 2 clk after release
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(0, 0, 0);
            check("bclk", 32'(o_blink_clk), ((k / 2) % 2));
            check("clk_mode", 32'(o_mode), 0);
            check("clk_dis", 32'(dis), 3'b111);
        end

        // pos/inc ignored in CLOCK
        tick(0, 1, 0);
        check("clk_pos_ign", 32'(o_mode), 0);
        tick(0, 0, 1);
        check("clk_inc_ign_mode", 32'(o_mode), 0);
        tick(0, 0, 0);
        check("clk_inc_ign", 32'(inc), 0);

        // Enter SET_SEC; dis_sec blinks 4 on / 4 off
        tick(1, 0, 0);
        check("set_sec_mode", 32'(o_mode), 1);
        check("set_sec_dis0", 32'(dis), 3'b111);
        for (int k = 1; k <= 7; k++) begin
            tick(0, 0, 0);
            check("sec_blink", 32'(dis), (k < 4) ? 3'b111 : 3'b110);
        end
        tick(0, 1, 0);
        check("pos_min", 32'(o_mode), 2);
        check("pos_min_dis", 32'(dis), 3'b111);
        tick(0, 1, 0);
        check("pos_hour", 32'(o_mode), 3);
        tick(0, 1, 0);
        check("pos_wrap", 32'(o_mode), 1);

        // SET_MIN increment latency and blink restart
        tick(0, 1, 0);
        check("to_min", 32'(o_mode), 2);
        tick(0, 0, 0);
        tick(0, 0, 1);
        check("inc_min", 32'(inc), 3'b010);
        check("inc_min_dis", 32'(dis), 3'b111);
        for (int k = 1; k <= 4; k++) begin
            tick(0, 0, 0);
            check("inc_min_after", 32'(inc), 0);
            check("min_dis", 32'(dis), (k < 4) ? 3'b111 : 3'b101);
        end

        // Simultaneous pulses from SET_SEC: mode wins
        tick(0, 1, 0);
        tick(0, 1, 0);
        check("back_sec", 32'(o_mode), 1);
        tick(1, 1, 1);
        check("prio_mode", 32'(o_mode), 0);
        check("prio_inc", 32'(inc), 0);
        check("prio_dis", 32'(dis), 3'b111);

        // Idle timeout after 12 clk
        tick(1, 0, 0);
        for (int k = 1; k <= 11; k++) tick(0, 0, 0);
        check("to_before", 32'(o_mode), 1);
        tick(0, 0, 0);
        check("to_mode", 32'(o_mode), 0);
        check("to_dis", 32'(dis), 3'b111);

        // inc at clk 10 restarts the window
        tick(1, 0, 0);
        for (int k = 1; k <= 9; k++) tick(0, 0, 0);
        tick(0, 0, 1);
        check("to_inc_sec", 32'(inc), 3'b001);
        for (int k = 11; k <= 21; k++) tick(0, 0, 0);
        check("to2_before", 32'(o_mode), 1);
        tick(0, 0, 0);
        check("to2_mode", 32'(o_mode), 0);

        // SET_HOUR increment, hour digit blanked, then reset
        tick(1, 0, 0);
        tick(0, 1, 0);
        tick(0, 1, 0);
        check("hour_mode", 32'(o_mode), 3);
        tick(0, 0, 1);
        check("inc_hour", 32'(inc), 3'b100);
        for (int k = 1; k <= 4; k++) tick(0, 0, 0);
        check("hour_dark", 32'(dis), 3'b011);
        rst_n = 1'b0;
        tick(0, 0, 0);
        rst_n = 1'b1;
        check("rst2_mode", 32'(o_mode), 0);
        check("rst2_dis", 32'(dis), 3'b111);
        check("rst2_bclk", 32'(o_blink_clk), 0);
        tick(0, 0, 0);
        check("rst2_stay", 32'(o_mode), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
